// File: rtl/simd_mult_stream.sv
// Purpose     : pairs unsigned (a,b) beats onto the two 8x8 lanes of a SIMD-split DSP and returns products in input order.
// Latency     : out_valid rises three cycles after the accepting edge of a pair's last beat (DSP_LAT+2 cycles after the issue cycle).
// Backpressure: in_ready is high only while at least two result slots are unclaimed; out_ready stalls pop from the result FIFO.
//
// Ports:
//   clk, rst_n                        clock, asynchronous active-low reset
//   in_valid/in_ready/in_a/in_b/in_last  operand stream; in_last flushes an unpaired beat as a single
//   a0,b0,a1,b1                       registered lane operands towards the DSP input registers
//   z0,z1                             lane products returned from the DSP
//   out_valid/out_ready/out_z         product stream, same order as the operand beats

// Purpose     : result FIFO with a dual write port (one or two entries per edge) and a single read port.
// Latency     : a write is visible at the head on the cycle after the write edge.
// Backpressure: none internally; the writer guarantees space, overflow is flagged by an assertion.
//
// Ports:
//   wr_vld/wr_two/wr_dat0/wr_dat1   write wr_dat0, and also wr_dat1 when wr_two, in one edge
//   rd_rdy/rd_vld/rd_dat            pop interface, rd_dat is the head entry
//   count                           current occupancy (0..DEPTH)
module simd_mult_stream_fifo #(
    parameter int W     = 16,
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_vld,
    input  logic          wr_two,
    input  logic [W-1:0]  wr_dat0,
    input  logic [W-1:0]  wr_dat1,
    input  logic          rd_rdy,
    output logic          rd_vld,
    output logic [W-1:0]  rd_dat,
    output logic [CW-1:0] count
);
    localparam int PW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] wr_n;
    logic          pop;

    assign rd_vld = (count != '0);
    assign rd_dat = mem[rd_ptr];
    assign pop    = rd_vld & rd_rdy;

    always_comb begin
        wr_n = '0;
        if (wr_vld) begin
            wr_n = wr_two ? CW'(2) : CW'(1);
        end
    end

    // Storage carries no reset; occupancy and pointers alone define validity.
    always_ff @(posedge clk) begin
        if (wr_vld) begin
            mem[wr_ptr] <= wr_dat0;
            if (wr_two) begin
                mem[wr_ptr + 1'b1] <= wr_dat1;
            end
        end
    end

    // DEPTH is a power of two, so pointer arithmetic wraps on its own.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + PW'(wr_n);
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + wr_n - CW'(pop);
        end
    end

    no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        ({1'b0, count} + {1'b0, wr_n} <= (CW+1)'(DEPTH) + (CW+1)'(pop)));
endmodule

module simd_mult_stream #(
    parameter int A_W        = 8,
    parameter int B_W        = 8,
    parameter int Z_W        = 16,
    parameter int DSP_LAT    = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [A_W-1:0] in_a,
    input  logic [B_W-1:0] in_b,
    input  logic           in_last,
    output logic [A_W-1:0] a0,
    output logic [B_W-1:0] b0,
    output logic [A_W-1:0] a1,
    output logic [B_W-1:0] b1,
    input  logic [Z_W-1:0] z0,
    input  logic [Z_W-1:0] z1,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [Z_W-1:0] out_z
);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [CW:0] READY_MAX = (CW+1)'(FIFO_DEPTH - 2);

    typedef enum logic {
        EMPTY = 1'b0,
        HALF  = 1'b1
    } pair_state_t;

    pair_state_t    state_q;
    pair_state_t    state_d;
    logic [A_W-1:0] a0_d;
    logic [B_W-1:0] b0_d;
    logic [A_W-1:0] a1_d;
    logic [B_W-1:0] b1_d;
    logic           accept;
    logic           issue_vld;
    logic           issue_two;

    // Delay line: stage 0 is loaded at the accepting edge, stage DSP_LAT is
    // the head that lines up with z0/z1 for that issue.
    logic [DSP_LAT:0] dl_vld_q;
    logic [DSP_LAT:0] dl_two_q;
    logic             head_vld;
    logic             head_two;

    logic [CW-1:0]  inflight_q;
    logic [CW-1:0]  issue_n;
    logic [CW-1:0]  retire_n;
    logic [CW-1:0]  fifo_cnt;
    logic [CW:0]    used_slots;

    // Ready depends only on registered counters so there is no in_valid ->
    // in_ready path. Two free slots cover the worst case of a completed pair.
    // Holding it low during reset keeps the upstream from seeing a ready
    // before the block is running.
    assign used_slots = {1'b0, fifo_cnt} + {1'b0, inflight_q};
    assign in_ready   = rst_n & (used_slots <= READY_MAX);
    assign accept     = in_valid & in_ready;

    assign head_vld = dl_vld_q[DSP_LAT];
    assign head_two = dl_two_q[DSP_LAT];

    always_comb begin
        state_d   = state_q;
        a0_d      = a0;
        b0_d      = b0;
        a1_d      = a1;
        b1_d      = b1;
        issue_vld = 1'b0;
        issue_two = 1'b0;
        if (accept) begin
            unique case (state_q)
                EMPTY: begin
                    a0_d = in_a;
                    b0_d = in_b;
                    if (in_last) begin
                        // Lone beat at a burst end goes out on lane 0;
                        // lane 1 is zeroed and its product is never collected.
                        a1_d      = '0;
                        b1_d      = '0;
                        issue_vld = 1'b1;
                    end else begin
                        state_d = HALF;
                    end
                end
                HALF: begin
                    a1_d      = in_a;
                    b1_d      = in_b;
                    issue_vld = 1'b1;
                    issue_two = 1'b1;
                    state_d   = EMPTY;
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            a0      <= '0;
            b0      <= '0;
            a1      <= '0;
            b1      <= '0;
        end else begin
            state_q <= state_d;
            a0      <= a0_d;
            b0      <= b0_d;
            a1      <= a1_d;
            b1      <= b1_d;
        end
    end

    // Lane registers may be overwritten at the edge after issue: the DSP
    // input registers sample the old operands at that same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dl_vld_q <= '0;
            dl_two_q <= '0;
        end else begin
            dl_vld_q[0] <= issue_vld;
            dl_two_q[0] <= issue_two;
            for (int i = 1; i <= DSP_LAT; i++) begin
                dl_vld_q[i] <= dl_vld_q[i-1];
                dl_two_q[i] <= dl_two_q[i-1];
            end
        end
    end

    always_comb begin
        issue_n  = '0;
        retire_n = '0;
        if (issue_vld) begin
            issue_n = issue_two ? CW'(2) : CW'(1);
        end
        if (head_vld) begin
            retire_n = head_two ? CW'(2) : CW'(1);
        end
    end

    // Products move from inflight to the FIFO at the same edge, so the sum
    // used for credit does not change on collection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight_q <= '0;
        end else begin
            inflight_q <= inflight_q + issue_n - retire_n;
        end
    end

    // z is stored verbatim; Z_W is expected to be at least A_W+B_W.
    simd_mult_stream_fifo #(
        .W     (Z_W),
        .DEPTH (FIFO_DEPTH),
        .CW    (CW)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_vld  (head_vld),
        .wr_two  (head_two),
        .wr_dat0 (z0),
        .wr_dat1 (z1),
        .rd_rdy  (out_ready),
        .rd_vld  (out_valid),
        .rd_dat  (out_z),
        .count   (fifo_cnt)
    );
endmodule

// File: tb/tb_simd_mult_stream.sv
// Purpose     : directed bench for simd_mult_stream with a registered-input DSP model on the lane ports.
// Latency     : DSP model returns a0*b0 / a1*b1 one edge after the lane registers settle.
// Backpressure: out_ready is driven by the directed steps; products are captured whenever a pop occurs.
module tb_simd_mult_stream;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_a;
    logic [7:0]  in_b;
    logic        in_last;
    logic [7:0]  a0, b0, a1, b1;
    logic [15:0] z0 = '0;
    logic [15:0] z1 = '0;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_z;

    int checks = 0;
    int errors = 0;
    logic [15:0] exp_q[$];
    logic [15:0] got_q[$];

    always #5 clk = ~clk;

    simd_mult_stream dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_last   (in_last),
        .a0        (a0),
        .b0        (b0),
        .a1        (a1),
        .b1        (b1),
        .z0        (z0),
        .z1        (z1),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_z     (out_z)
    );

    // DSP with registered inputs: product valid one edge after sampling.
    always @(posedge clk) begin
        z0 <= {8'd0, a0} * {8'd0, b0};
        z1 <= {8'd0, a1} * {8'd0, b1};
    end

    // Inputs only change #1 after a rising edge, so the values seen here
    // are exactly those the next rising edge acts on.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) got_q.push_back(out_z);
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] a, input logic [7:0] b, input logic last);
        int n;
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_last  = last;
        n = 0;
        while (!in_ready && n < 200) begin
            step();
            n++;
        end
        check("send_ready", {31'd0, in_ready}, 1);
        step();
        in_valid = 1'b0;
        in_last  = 1'b0;
        exp_q.push_back({8'd0, a} * {8'd0, b});
    endtask

    task automatic drain(input string tag);
        int n;
        out_ready = 1'b1;
        n = 0;
        while (got_q.size() < exp_q.size() && n < 100) begin
            step();
            n++;
        end
        repeat (4) step();
        check({tag, "_count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            check($sformatf("%s_z%0d", tag, i), {16'd0, got_q[i]}, {16'd0, exp_q[i]});
        end
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        repeat (3) step();
        check("rst_in_ready", {31'd0, in_ready}, 0);
        check("rst_out_valid", {31'd0, out_valid}, 0);
        check("rst_lanes", {a0, b0, a1, b1}, 0);
        rst_n = 1'b1;
        step();
        check("post_rst_in_ready", {31'd0, in_ready}, 1);

        // 1: back-to-back pair, out_valid three cycles after second accept
        out_ready = 1'b1;
        send(8'd3, 8'd5, 1'b0);
        check("t1_ready_mid", {31'd0, in_ready}, 1);
        send(8'd7, 8'd9, 1'b0);
        check("t1_ready_after", {31'd0, in_ready}, 1);
        check("t1_lat1", {31'd0, out_valid}, 0);
        step();
        check("t1_lat2", {31'd0, out_valid}, 0);
        step();
        check("t1_lat3_valid", {31'd0, out_valid}, 1);
        check("t1_first_z", {16'd0, out_z}, 15);
        step();
        check("t1_second_z", {16'd0, out_z}, 63);
        drain("t1");

        // 2: single beat with last zeroes lane 1
        send(8'd255, 8'd255, 1'b1);
        check("t2_a0b0", {16'd0, a0, b0}, 32'h0000_FFFF);
        check("t2_a1b1", {16'd0, a1, b1}, 0);
        drain("t2");
        check("t2_empty", {31'd0, out_valid}, 0);

        // 4: odd burst, third beat goes out alone on lane 0
        send(8'd1, 8'd2, 1'b0);
        send(8'd3, 8'd4, 1'b0);
        send(8'd5, 8'd6, 1'b1);
        check("t4_lane0", {16'd0, a0, b0}, 32'h0000_0506);
        check("t4_lane1", {16'd0, a1, b1}, 0);
        drain("t4");

        // 3: out_ready low, credit stops the stream after four beats
        out_ready = 1'b0;
        send(8'd1, 8'd10, 1'b0);
        send(8'd2, 8'd11, 1'b0);
        send(8'd3, 8'd12, 1'b0);
        send(8'd4, 8'd13, 1'b0);
        check("t3_ready_drop", {31'd0, in_ready}, 0);
        in_valid = 1'b1;
        in_a     = 8'd5;
        in_b     = 8'd14;
        repeat (4) step();
        check("t3_ready_held_low", {31'd0, in_ready}, 0);
        check("t3_out_valid", {31'd0, out_valid}, 1);
        check("t3_head", {16'd0, out_z}, 10);
        out_ready = 1'b1;
        send(8'd5, 8'd14, 1'b0);
        out_ready = 1'b0;
        repeat (3) step();
        check("t3_half_held", {16'd0, a0, b0}, 32'h0000_050E);
        send(8'd6, 8'd15, 1'b0);
        drain("t3");

        // 5: pop and two-entry write on the same edge with two entries stored
        out_ready = 1'b0;
        send(8'd1, 8'd1, 1'b0);
        send(8'd2, 8'd2, 1'b0);
        repeat (3) step();
        check("t5_pre_valid", {31'd0, out_valid}, 1);
        check("t5_pre_ready", {31'd0, in_ready}, 1);
        send(8'd3, 8'd3, 1'b0);
        send(8'd4, 8'd4, 1'b0);
        step();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("t5_cnt3_ready", {31'd0, in_ready}, 0);
        check("t5_head", {16'd0, out_z}, 4);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("t5_cnt2_ready", {31'd0, in_ready}, 1);
        drain("t5");

        // 6: reset with a pair in the delay line and a half pair pending
        out_ready = 1'b0;
        send(8'd10, 8'd10, 1'b0);
        send(8'd11, 8'd11, 1'b0);
        send(8'd12, 8'd12, 1'b0);
        rst_n = 1'b0;
        #1;
        check("t6_rst_out_valid", {31'd0, out_valid}, 0);
        check("t6_rst_in_ready", {31'd0, in_ready}, 0);
        check("t6_rst_lane0", {16'd0, a0, b0}, 0);
        repeat (2) step();
        rst_n = 1'b1;
        exp_q.delete();
        got_q.delete();
        step();
        check("t6_post_ready", {31'd0, in_ready}, 1);
        out_ready = 1'b1;
        send(8'd2, 8'd2, 1'b1);
        drain("t6");
        check("t6_empty", {31'd0, out_valid}, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
